vctcxo_tamer_pps_monitor: RTL and testbench

Measures the free-running VCTCXO clock against an external 1PPS reference over 1 s, 10 s and 100 s windows. Reports signed frequency-error counts and sticky out-of-tolerance flags. Sits directly upstream of the VCTCXO tamer control PIO: `status[3:0]` drives that PIO's 4-bit input port, and the Nios polls it to decide when to read the error registers and retune the DAC.

---
 rtl/vctcxo_tamer_pps_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_vctcxo_tamer_pps_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vctcxo_tamer_pps_monitor.sv
`default_nettype none
// vctcxo_tamer_pps_monitor: measures clk against 1PPS over 1 s / 10 s / 100 s windows,
// reporting signed frequency-error counts and sticky out-of-tolerance flags. Rev 1.0
module vctcxo_tamer_pps_monitor #(
  parameter int unsigned CLK_HZ   = 30720000,
  parameter int unsigned TOL_1S   = 2,
  parameter int unsigned TOL_10S  = 20,
  parameter int unsigned TOL_100S = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pps_in,
  input  logic        enable,
  input  logic        clear,
  output logic [3:0]  status,
  output logic [31:0] err_1s,
  output logic [31:0] err_10s,
  output logic [31:0] err_100s,
  output logic        upd_1s,
  output logic        upd_10s,
  output logic        upd_100s
);

  localparam logic [63:0] HZ_64    = 64'(CLK_HZ);
  localparam logic [31:0] NOM_1S   = 32'(HZ_64);
  localparam logic [31:0] NOM_10S  = 32'(HZ_64 * 64'd10);
  localparam logic [31:0] NOM_100S = 32'(HZ_64 * 64'd100);
  localparam logic [31:0] TIMEOUT  = 32'(HZ_64 + HZ_64 / 64'd4);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_d;

  logic        pps_meta;
  logic        pps_sync;
  logic        pps_prev;
  logic        pps_pulse;

  logic [31:0] cnt1;
  logic [31:0] cnt10;
  logic [31:0] cnt100;
  logic [6:0]  pcnt;
  logic [6:0]  pcnt_nxt;

  logic        arm;
  logic        meas;
  logic        tmo;
  logic        win10;
  logic        win100;
  logic [31:0] d1;
  logic [31:0] d10;
  logic [31:0] d100;
  logic        set1;
  logic        set10;
  logic        set100;

  logic        pps_valid;
  logic        err1_flag;
  logic        err10_flag;
  logic        err100_flag;

  function automatic logic over_tol(input logic [31:0] e, input logic [31:0] tol);
    logic signed [32:0] se;
    logic signed [32:0] st;
    se = {e[31], e};
    st = {1'b0, tol};
    return (se > st) || (se < -st);
  endfunction

  // Registered edge detect gives a one-cycle pulse after the two synchronizer stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pps_meta  <= 1'b0;
      pps_sync  <= 1'b0;
      pps_prev  <= 1'b0;
      pps_pulse <= 1'b0;
    end else begin
      pps_meta  <= pps_in;
      pps_sync  <= pps_meta;
      pps_prev  <= pps_sync;
      pps_pulse <= pps_sync & ~pps_prev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    arm     = 1'b0;
    meas    = 1'b0;
    tmo     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pps_pulse) begin
            state_d = ST_RUN;
            arm     = 1'b1;
          end
        end
        ST_RUN: begin
          // A pulse landing on the timeout cycle still counts as a measurement.
          if (pps_pulse) begin
            meas = 1'b1;
          end else if (cnt1 == TIMEOUT) begin
            tmo     = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pcnt_nxt = (pcnt == 7'd99) ? 7'd0 : pcnt + 7'd1;
    win10    = meas && ((pcnt_nxt % 7'd10) == 7'd0);
    win100   = meas && (pcnt_nxt == 7'd0);
    d1       = cnt1 - NOM_1S;
    d10      = cnt10 - NOM_10S;
    d100     = cnt100 - NOM_100S;
    set1     = meas && over_tol(d1, 32'(TOL_1S));
    set10    = win10 && over_tol(d10, 32'(TOL_10S));
    set100   = win100 && over_tol(d100, 32'(TOL_100S));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt1   <= '0;
      cnt10  <= '0;
      cnt100 <= '0;
      pcnt   <= '0;
    end else if (!enable) begin
      cnt1   <= '0;
      cnt10  <= '0;
      cnt100 <= '0;
      pcnt   <= '0;
    end else if (arm) begin
      cnt1   <= 32'd1;
      cnt10  <= 32'd1;
      cnt100 <= 32'd1;
      pcnt   <= '0;
    end else if (meas) begin
      cnt1   <= 32'd1;
      cnt10  <= win10 ? 32'd1 : cnt10 + 32'd1;
      cnt100 <= win100 ? 32'd1 : cnt100 + 32'd1;
      pcnt   <= pcnt_nxt;
    end else if (state == ST_RUN && !tmo) begin
      cnt1   <= cnt1 + 32'd1;
      cnt10  <= cnt10 + 32'd1;
      cnt100 <= cnt100 + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_1s      <= '0;
      err_10s     <= '0;
      err_100s    <= '0;
      upd_1s      <= 1'b0;
      upd_10s     <= 1'b0;
      upd_100s    <= 1'b0;
      pps_valid   <= 1'b0;
      err1_flag   <= 1'b0;
      err10_flag  <= 1'b0;
      err100_flag <= 1'b0;
    end else begin
      upd_1s    <= meas;
      upd_10s   <= win10;
      upd_100s  <= win100;
      pps_valid <= (state_d == ST_RUN);
      if (meas) begin
        err_1s <= d1;
      end
      if (win10) begin
        err_10s <= d10;
      end
      if (win100) begin
        err_100s <= d100;
      end
      // A set on the same edge as clear takes priority.
      err1_flag   <= set1 | (err1_flag & ~clear);
      err10_flag  <= set10 | (err10_flag & ~clear);
      err100_flag <= set100 | (err100_flag & ~clear);
    end
  end

  assign status = {err100_flag, err10_flag, err1_flag, pps_valid};

endmodule
`default_nettype wire

// File: tb/tb_vctcxo_tamer_pps_monitor.sv
`default_nettype none
// tb_vctcxo_tamer_pps_monitor: randomized PPS stimulus checked against a
// timestamp-based reference model of the frequency monitor.
module tb_vctcxo_tamer_pps_monitor;

  localparam int HZ   = 100;
  localparam int T1   = 1;
  localparam int T10  = 5;
  localparam int T100 = 20;

  logic        clk;
  logic        reset_n;
  logic        pps_in;
  logic        enable;
  logic        clear;
  logic [3:0]  status;
  logic [31:0] err_1s;
  logic [31:0] err_10s;
  logic [31:0] err_100s;
  logic        upd_1s;
  logic        upd_10s;
  logic        upd_100s;

  vctcxo_tamer_pps_monitor #(
    .CLK_HZ   (HZ),
    .TOL_1S   (T1),
    .TOL_10S  (T10),
    .TOL_100S (T100)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pps_in   (pps_in),
    .enable   (enable),
    .clear    (clear),
    .status   (status),
    .err_1s   (err_1s),
    .err_10s  (err_10s),
    .err_100s (err_100s),
    .upd_1s   (upd_1s),
    .upd_10s  (upd_10s),
    .upd_100s (upd_100s)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  bit pulse_cyc [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit over(input logic [31:0] e, input int tol);
    return ($signed(e) > tol) || ($signed(e) < -tol);
  endfunction

  // Reference model: measurements are differences of pulse timestamps.
  bit          armed;
  int          last1, last10, last100, npul;
  bit [2:0]    flags;
  logic [3:0]  exp_status;
  logic [2:0]  exp_upd;
  logic [31:0] exp_e1, exp_e10, exp_e100;

  initial begin
    int       c;
    bit       pulse;
    bit [2:0] set;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        armed = 0; flags = 0; exp_status = 0; exp_upd = 0;
        exp_e1 = 0; exp_e10 = 0; exp_e100 = 0;
      end else begin
        check("status", {28'd0, status}, {28'd0, exp_status});
        check("upd", {29'd0, upd_100s, upd_10s, upd_1s}, {29'd0, exp_upd});
        check("err_1s", err_1s, exp_e1);
        check("err_10s", err_10s, exp_e10);
        check("err_100s", err_100s, exp_e100);
        c       = cyc;
        pulse   = pulse_cyc.exists(c);
        set     = 0;
        exp_upd = 0;
        if (!enable) begin
          armed = 0;
        end else if (!armed) begin
          if (pulse) begin
            armed = 1; last1 = c; last10 = c; last100 = c; npul = 0;
          end
        end else if (pulse) begin
          npul++;
          e = 32'(c - last1 - HZ);
          exp_e1 = e; exp_upd[0] = 1; set[0] = over(e, T1); last1 = c;
          if (npul % 10 == 0) begin
            e = 32'(c - last10 - 10 * HZ);
            exp_e10 = e; exp_upd[1] = 1; set[1] = over(e, T10); last10 = c;
          end
          if (npul % 100 == 0) begin
            e = 32'(c - last100 - 100 * HZ);
            exp_e100 = e; exp_upd[2] = 1; set[2] = over(e, T100); last100 = c;
          end
        end else if (c - last1 == HZ + HZ / 4) begin
          armed = 0;
        end
        flags      = set | (flags & ~{3{clear}});
        exp_status = {flags, armed};
      end
    end
  end

  // One PPS period: rise at a random sub-cycle offset, high 5 cycles; clear
  // pulses for one cycle clr_off cycles after the rise cycle (if >0).
  task automatic send_pps(input int period, input int clr_off);
    int off;
    off = $urandom_range(0, 7);
    #(off);
    pps_in = 1'b1;
    pulse_cyc[cyc + 3] = 1'b1;
    for (int i = 1; i < period; i++) begin
      @(posedge clk); #1;
      pps_in = (i < 5);
      clear  = (i == clr_off);
    end
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int p;
    int co;
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; pps_in = 1'b0;
    wait_cyc(3);
    check("rst_status", {28'd0, status}, 32'd0);
    check("rst_err_1s", err_1s, 32'd0);
    check("rst_upd", {29'd0, upd_100s, upd_10s, upd_1s}, 32'd0);
    reset_n = 1'b1;
    wait_cyc(2);
    enable = 1'b1;
    wait_cyc(2);

    for (int i = 0; i < 102; i++) send_pps(100, -1);   // exact period
    for (int i = 0; i < 12; i++) send_pps(102, -1);    // slow
    send_pps(103, 3);                                  // clear races a flag set
    send_pps(100, 50);                                 // lone clear
    for (int i = 0; i < 4; i++) send_pps(99, -1);      // fast, within tolerance

    for (int i = 0; i < 3; i++) send_pps(100, -1);     // PPS loss then recovery
    send_pps(300, -1);
    for (int i = 0; i < 12; i++) send_pps(100, -1);

    for (int i = 0; i < 5; i++) send_pps(100, -1);     // enable drop mid-run
    wait_cyc(10);
    enable = 1'b0;
    wait_cyc(10);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) send_pps(100, -1);

    for (int i = 0; i < 120; i++) begin                // randomized periods
      p  = $urandom_range(97, 103);
      if ($urandom_range(0, 49) == 0) p = 200;
      co = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p - 1) : -1;
      send_pps(p, co);
    end

    for (int i = 0; i < 2; i++) send_pps(102, -1);     // reset mid-run
    wait_cyc(20);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_status", {28'd0, status}, 32'd0);
    check("async_rst_err_1s", err_1s, 32'd0);
    check("async_rst_err_10s", err_10s, 32'd0);
    check("async_rst_err_100s", err_100s, 32'd0);
    check("async_rst_upd", {29'd0, upd_100s, upd_10s, upd_1s}, 32'd0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 3; i++) send_pps(100, -1);
    wait_cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
